// File: rtl/lcd_ctrl.sv
// lcd_ctrl: HD44780 character LCD sequencer that runs power-up init, then issues timed RS/DATA/EN writes.
// Optional macro LCD_CTRL_FIFO_EN places a 4-entry {rs,data} request FIFO in front of the sequencer.
module lcd_ctrl #(
   parameter int unsigned T_PWRUP = 750000,
   parameter int unsigned T_AS    = 4,
   parameter int unsigned T_PW    = 25,
   parameter int unsigned T_H     = 4,
   parameter int unsigned T_CMD   = 2000,
   parameter int unsigned T_CLR   = 82000
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       req_valid_i,
   output logic       req_ready_o,
   input  logic       req_rs_i,
   input  logic [7:0] req_data_i,
   output logic       init_done_o,
   output logic       busy_o,
   output logic [7:0] lcd_data_o,
   output logic       lcd_rs_o,
   output logic       lcd_rw_o,
   output logic       lcd_en_o,
   output logic       lcd_on_o
);

   localparam int unsigned CNT_MAX = (T_PWRUP > T_CLR) ? T_PWRUP : T_CLR;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0] LIM_PWRUP = CNT_W'(T_PWRUP - 1);
   localparam logic [CNT_W-1:0] LIM_AS    = CNT_W'(T_AS - 1);
   localparam logic [CNT_W-1:0] LIM_PW    = CNT_W'(T_PW - 1);
   localparam logic [CNT_W-1:0] LIM_H     = CNT_W'(T_H - 1);
   localparam logic [CNT_W-1:0] LIM_CMD   = CNT_W'(T_CMD - 1);
   localparam logic [CNT_W-1:0] LIM_CLR   = CNT_W'(T_CLR - 1);

   typedef enum logic [2:0] {
      S_PWRUP,
      S_SETUP,
      S_PULSE,
      S_HOLD,
      S_EXEC,
      S_IDLE
   } state_t;

   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [1:0]       idx_q;
   logic [7:0]       data_q;
   logic             rs_q;
   logic             en_q;
   logic             on_q;
   logic             done_q;
   logic             busy_q;
   logic             ready_q;

   logic             take;
   logic             take_rs;
   logic [7:0]       take_data;
   logic             is_slow;
   logic [CNT_W-1:0] exec_lim;

   // Function set 8-bit/2-line, display on, clear, entry mode increment.
   function automatic logic [7:0] init_byte(input logic [1:0] idx);
      case (idx)
         2'd0:    init_byte = 8'h38;
         2'd1:    init_byte = 8'h0C;
         2'd2:    init_byte = 8'h01;
         default: init_byte = 8'h06;
      endcase
   endfunction

   assign is_slow  = ~rs_q & ((data_q == 8'h01) | (data_q == 8'h02) | (data_q == 8'h03));
   assign exec_lim = is_slow ? LIM_CLR : LIM_CMD;

`ifdef LCD_CTRL_FIFO_EN
   logic [8:0] fifo_mem_q [4];
   logic [1:0] wr_ptr_q;
   logic [1:0] rd_ptr_q;
   logic [2:0] fcnt_q;
   logic [2:0] fcnt_d;
   logic       push;
   logic       pop;

   assign push = req_valid_i & ready_q;
   assign pop  = (state_q == S_IDLE) & (fcnt_q != 3'd0) & done_q;

   always_comb begin
      fcnt_d = fcnt_q;
      case ({push, pop})
         2'b10:   fcnt_d = fcnt_q + 3'd1;
         2'b01:   fcnt_d = fcnt_q - 3'd1;
         default: fcnt_d = fcnt_q;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         fcnt_q   <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 2'd1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 2'd1;
         fcnt_q <= fcnt_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) fifo_mem_q[wr_ptr_q] <= {req_rs_i, req_data_i};
   end

   assign take                = pop;
   assign {take_rs, take_data} = fifo_mem_q[rd_ptr_q];
   assign busy_o              = busy_q | (fcnt_q != 3'd0);
`else
   assign take      = req_valid_i & ready_q;
   assign take_rs   = req_rs_i;
   assign take_data = req_data_i;
   assign busy_o    = busy_q;
`endif

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= S_PWRUP;
         cnt_q   <= '0;
         idx_q   <= '0;
         data_q  <= '0;
         rs_q    <= 1'b0;
         en_q    <= 1'b0;
         on_q    <= 1'b0;
         done_q  <= 1'b0;
         busy_q  <= 1'b1;
         ready_q <= 1'b0;
      end else begin
         on_q  <= 1'b1;
         cnt_q <= cnt_q + CNT_W'(1);
         case (state_q)
            S_PWRUP: begin
               if (cnt_q == LIM_PWRUP) begin
                  state_q <= S_SETUP;
                  cnt_q   <= '0;
                  data_q  <= init_byte(2'd0);
                  rs_q    <= 1'b0;
               end
            end
            S_SETUP: begin
               if (cnt_q == LIM_AS) begin
                  state_q <= S_PULSE;
                  cnt_q   <= '0;
                  en_q    <= 1'b1;
               end
            end
            S_PULSE: begin
               if (cnt_q == LIM_PW) begin
                  state_q <= S_HOLD;
                  cnt_q   <= '0;
                  en_q    <= 1'b0;
               end
            end
            S_HOLD: begin
               if (cnt_q == LIM_H) begin
                  state_q <= S_EXEC;
                  cnt_q   <= '0;
               end
            end
            S_EXEC: begin
               if (cnt_q == exec_lim) begin
                  cnt_q <= '0;
                  // idx_q parks at 3 once init is over, so user writes fall through to IDLE.
                  if (idx_q != 2'd3) begin
                     idx_q   <= idx_q + 2'd1;
                     data_q  <= init_byte(idx_q + 2'd1);
                     rs_q    <= 1'b0;
                     state_q <= S_SETUP;
                  end else begin
                     done_q  <= 1'b1;
                     state_q <= S_IDLE;
                     busy_q  <= 1'b0;
                     ready_q <= 1'b1;
                  end
               end
            end
            S_IDLE: begin
               cnt_q <= '0;
               if (take) begin
                  state_q <= S_SETUP;
                  data_q  <= take_data;
                  rs_q    <= take_rs;
                  busy_q  <= 1'b1;
                  ready_q <= 1'b0;
               end
            end
            default: begin
               state_q <= S_PWRUP;
               cnt_q   <= '0;
            end
         endcase
`ifdef LCD_CTRL_FIFO_EN
         // With the FIFO, ready only reflects free space and overrides the sequencer's view.
         ready_q <= (fcnt_d != 3'd4);
`endif
      end
   end

   assign req_ready_o = ready_q;
   assign init_done_o = done_q;
   assign lcd_data_o  = data_q;
   assign lcd_rs_o    = rs_q;
   assign lcd_rw_o    = 1'b0;
   assign lcd_en_o    = en_q;
   assign lcd_on_o    = on_q;

endmodule

// File: tb/tb_lcd_ctrl.sv
// Self-checking bench for lcd_ctrl: scoreboard of expected LCD writes checked by an EN-pulse monitor.
`timescale 1ns/1ps
module tb_lcd_ctrl;

   localparam int T_PWRUP = 20;
   localparam int T_AS    = 2;
   localparam int T_PW    = 3;
   localparam int T_H     = 2;
   localparam int T_CMD   = 10;
   localparam int T_CLR   = 30;
   localparam int WR_CMD  = T_AS + T_PW + T_H + T_CMD;
   localparam int WR_CLR  = T_AS + T_PW + T_H + T_CLR;
   localparam int INIT_CYC = T_PWRUP + 3 * WR_CMD + WR_CLR;
   localparam int LIMIT   = 2000;
`ifdef LCD_CTRL_FIFO_EN
   localparam int IDLE_EXTRA = 1;
`else
   localparam int IDLE_EXTRA = 0;
`endif

   logic       clk = 1'b0;
   logic       rst_i = 1'b1;
   logic       req_valid_i = 1'b0;
   logic       req_ready_o;
   logic       req_rs_i = 1'b0;
   logic [7:0] req_data_i = 8'h00;
   logic       init_done_o;
   logic       busy_o;
   logic [7:0] lcd_data_o;
   logic       lcd_rs_o;
   logic       lcd_rw_o;
   logic       lcd_en_o;
   logic       lcd_on_o;

   always #5 clk = ~clk;

   lcd_ctrl #(
      .T_PWRUP(T_PWRUP), .T_AS(T_AS), .T_PW(T_PW),
      .T_H(T_H), .T_CMD(T_CMD), .T_CLR(T_CLR)
   ) dut (
      .clk_i(clk), .rst_i(rst_i),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
      .req_rs_i(req_rs_i), .req_data_i(req_data_i),
      .init_done_o(init_done_o), .busy_o(busy_o),
      .lcd_data_o(lcd_data_o), .lcd_rs_o(lcd_rs_o), .lcd_rw_o(lcd_rw_o),
      .lcd_en_o(lcd_en_o), .lcd_on_o(lcd_on_o)
   );

   typedef struct {
      logic       rs;
      logic [7:0] data;
      int         exec;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_errors = 0;
   int   n_writes = 0;

   int         cyc = 0;
   int         lo_stable = 0;
   int         width = 0;
   int         hold_left = 0;
   int         fall_cyc = 0;
   int         last_exec = 0;
   int         cur_exec = 0;
   bit         in_pulse = 0;
   bit         armed = 0;
   bit         rw_bad = 0;
   bit         pulse_chg = 0;
   logic [8:0] prev_bus = '0;
   logic [8:0] pulse_bus = '0;

   task automatic expect_write(input logic rs, input logic [7:0] d);
      exp_t e;
      e.rs   = rs;
      e.data = d;
      e.exec = (!rs && d >= 8'h01 && d <= 8'h03) ? T_CLR : T_CMD;
      exp_q.push_back(e);
   endtask

   task automatic expect_init();
      expect_write(1'b0, 8'h38);
      expect_write(1'b0, 8'h0C);
      expect_write(1'b0, 8'h01);
      expect_write(1'b0, 8'h06);
   endtask

   // Watches the LCD pins every cycle: setup/hold stability, EN width, data vs scoreboard, EXEC length.
   task automatic monitor();
      exp_t       e;
      logic [8:0] bus;
      int         exp_gap;
      forever begin
         @(negedge clk);
         cyc++;
         bus = {lcd_rs_o, lcd_data_o};
         if (rst_i) begin
            in_pulse  = 0;
            armed     = 0;
            hold_left = 0;
            lo_stable = 0;
            prev_bus  = bus;
         end else begin
            if (lcd_rw_o !== 1'b0) rw_bad = 1;
            if (hold_left > 0) begin
               n_checks++;
               if (bus !== pulse_bus || lcd_en_o !== 1'b0) begin
                  n_errors++;
                  $display("FAIL hold: rs/data=%h en=%b, required rs/data=%h en=0", bus, lcd_en_o, pulse_bus);
               end
               hold_left--;
            end
            if (armed && busy_o === 1'b0) begin
               n_checks++;
               if (cyc - fall_cyc != T_H + last_exec) begin
                  n_errors++;
                  $display("FAIL exec_to_idle: %0d cycles after EN fall, required %0d", cyc - fall_cyc, T_H + last_exec);
               end
               armed = 0;
            end
            if (lcd_en_o === 1'b1 && !in_pulse) begin
               n_writes++;
               n_checks++;
               if (lo_stable < T_AS || bus !== prev_bus) begin
                  n_errors++;
                  $display("FAIL setup: stable %0d cycles before EN rise, required %0d", lo_stable, T_AS);
               end
               if (armed) begin
                  exp_gap = T_H + last_exec + T_AS + ((init_done_o === 1'b1) ? IDLE_EXTRA : 0);
                  n_checks++;
                  if (cyc - fall_cyc != exp_gap) begin
                     n_errors++;
                     $display("FAIL gap: EN fall to rise %0d cycles, required %0d", cyc - fall_cyc, exp_gap);
                  end
                  armed = 0;
               end
               n_checks++;
               if (exp_q.size() == 0) begin
                  n_errors++;
                  $display("FAIL write: unexpected write rs/data=%h, required none", bus);
                  cur_exec = T_CMD;
               end else begin
                  e = exp_q.pop_front();
                  cur_exec = e.exec;
                  if (bus !== {e.rs, e.data}) begin
                     n_errors++;
                     $display("FAIL write: rs/data=%h, required %h", bus, {e.rs, e.data});
                  end
               end
               in_pulse  = 1;
               width     = 1;
               pulse_bus = bus;
               pulse_chg = 0;
            end else if (lcd_en_o === 1'b1) begin
               width++;
               if (bus !== pulse_bus) pulse_chg = 1;
            end else if (in_pulse) begin
               in_pulse = 0;
               n_checks++;
               if (width != T_PW || pulse_chg) begin
                  n_errors++;
                  $display("FAIL pulse: EN width %0d changed=%0d, required width %0d changed=0", width, pulse_chg, T_PW);
               end
               n_checks++;
               if (bus !== pulse_bus) begin
                  n_errors++;
                  $display("FAIL hold: rs/data=%h at EN fall, required %h", bus, pulse_bus);
               end
               fall_cyc  = cyc;
               last_exec = cur_exec;
               armed     = 1;
               hold_left = T_H - 1;
            end
            lo_stable = (lcd_en_o === 1'b0) ? ((bus === prev_bus) ? lo_stable + 1 : 1) : 0;
            prev_bus  = bus;
         end
      end
   endtask

   task automatic send_req(input logic rs, input logic [7:0] d, input bit keep, output int waited);
      expect_write(rs, d);
      req_rs_i    = rs;
      req_data_i  = d;
      req_valid_i = 1'b1;
      waited = 0;
      while (req_ready_o !== 1'b1 && waited < LIMIT) begin
         @(negedge clk);
         waited++;
      end
      n_checks++;
      if (waited >= LIMIT) begin
         n_errors++;
         $display("FAIL handshake: ready not seen within %0d cycles for %h, required ready", LIMIT, d);
      end
      @(posedge clk);
      #1;
      if (!keep) req_valid_i = 1'b0;
   endtask

   task automatic wait_init_done(output int k);
      k = 0;
      while (init_done_o !== 1'b1 && k < LIMIT) begin
         @(negedge clk);
         k++;
      end
   endtask

   task automatic busy_len(output int k);
      k = 0;
      @(negedge clk);
      while (busy_o === 1'b1 && k < LIMIT) begin
         k++;
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      n_checks++;
      if ({lcd_data_o, lcd_rs_o, lcd_rw_o, lcd_en_o} !== 11'b0) begin
         n_errors++;
         $display("FAIL reset_pins: data=%h rs=%b rw=%b en=%b, required all 0", lcd_data_o, lcd_rs_o, lcd_rw_o, lcd_en_o);
      end
      n_checks++;
      if (lcd_on_o !== 1'b0 || init_done_o !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_on_done: on=%b done=%b, required 0 0", lcd_on_o, init_done_o);
      end
      n_checks++;
      if (busy_o !== 1'b1 || req_ready_o !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_busy_ready: busy=%b ready=%b, required 1 0", busy_o, req_ready_o);
      end
      expect_init();
      #2 rst_i = 1'b0;
      @(negedge clk);
      n_checks++;
      if (lcd_on_o !== 1'b1) begin
         n_errors++;
         $display("FAIL lcd_on: %b one cycle after release, required 1", lcd_on_o);
      end
   endtask

   task automatic test_init();
      int k;
      wait_init_done(k);
      n_checks++;
      if (k + 1 != INIT_CYC) begin
         n_errors++;
         $display("FAIL init_time: init_done after %0d cycles, required %0d", k + 1, INIT_CYC);
      end
      n_checks++;
      if (busy_o !== 1'b0 || req_ready_o !== 1'b1) begin
         n_errors++;
         $display("FAIL init_idle: busy=%b ready=%b, required 0 1", busy_o, req_ready_o);
      end
      n_checks++;
      if (exp_q.size() != 0 || n_writes != 4) begin
         n_errors++;
         $display("FAIL init_writes: %0d writes, %0d pending, required 4 and 0", n_writes, exp_q.size());
      end
   endtask

   task automatic test_user_write();
      int w;
      int k;
      send_req(1'b1, 8'h41, 1'b0, w);
      busy_len(k);
      n_checks++;
      if (k != WR_CMD + IDLE_EXTRA) begin
         n_errors++;
         $display("FAIL user_busy: busy %0d cycles, required %0d", k, WR_CMD + IDLE_EXTRA);
      end
      n_checks++;
      if (req_ready_o !== 1'b1 || lcd_rs_o !== 1'b1 || lcd_data_o !== 8'h41) begin
         n_errors++;
         $display("FAIL user_idle: ready=%b rs=%b data=%h, required 1 1 41", req_ready_o, lcd_rs_o, lcd_data_o);
      end
   endtask

   task automatic test_back_to_back();
      int w;
      int k;
      int n0;
      n0 = n_writes;
      send_req(1'b1, 8'h48, 1'b1, w);
      send_req(1'b1, 8'h49, 1'b0, w);
      n_checks++;
      if (w != ((IDLE_EXTRA != 0) ? 0 : WR_CMD + 1)) begin
         n_errors++;
         $display("FAIL b2b_accept: second waited %0d cycles, required %0d", w, (IDLE_EXTRA != 0) ? 0 : WR_CMD + 1);
      end
      busy_len(k);
      n_checks++;
      if (n_writes - n0 != 2 || exp_q.size() != 0) begin
         n_errors++;
         $display("FAIL b2b_count: %0d writes, %0d pending, required 2 and 0", n_writes - n0, exp_q.size());
      end
   endtask

   task automatic test_exec_delays();
      int w;
      int k;
      send_req(1'b0, 8'h02, 1'b0, w);
      busy_len(k);
      n_checks++;
      if (k != WR_CLR + IDLE_EXTRA) begin
         n_errors++;
         $display("FAIL home_busy: busy %0d cycles, required %0d", k, WR_CLR + IDLE_EXTRA);
      end
      send_req(1'b0, 8'h80, 1'b0, w);
      busy_len(k);
      n_checks++;
      if (k != WR_CMD + IDLE_EXTRA) begin
         n_errors++;
         $display("FAIL ddram_busy: busy %0d cycles, required %0d", k, WR_CMD + IDLE_EXTRA);
      end
   endtask

   task automatic test_reset_mid_pulse();
      int w;
      int k;
      int n0;
      send_req(1'b1, 8'h5A, 1'b0, w);
      k = 0;
      while (lcd_en_o !== 1'b1 && k < LIMIT) begin
         @(negedge clk);
         k++;
      end
      n_checks++;
      if (k >= LIMIT) begin
         n_errors++;
         $display("FAIL mid_pulse: EN never rose, required a pulse");
      end
      #2 rst_i = 1'b1;
      #1;
      n_checks++;
      if (lcd_en_o !== 1'b0 || init_done_o !== 1'b0) begin
         n_errors++;
         $display("FAIL async_reset: en=%b done=%b, required 0 0", lcd_en_o, init_done_o);
      end
      n0 = n_writes;
      expect_init();
      @(negedge clk);
      @(negedge clk);
      #2 rst_i = 1'b0;
      wait_init_done(k);
      n_checks++;
      if (k != INIT_CYC || n_writes - n0 != 4 || exp_q.size() != 0) begin
         n_errors++;
         $display("FAIL reinit: %0d cycles %0d writes %0d pending, required %0d 4 0", k, n_writes - n0, exp_q.size(), INIT_CYC);
      end
   endtask

`ifdef LCD_CTRL_FIFO_EN
   task automatic test_fifo();
      int w;
      int k;
      int n0;
      @(negedge clk);
      #2 rst_i = 1'b1;
      n0 = n_writes;
      expect_init();
      @(negedge clk);
      @(negedge clk);
      #2 rst_i = 1'b0;
      for (int i = 0; i < 4; i++) send_req(1'b1, 8'h61 + 8'(i), 1'b1, w);
      n_checks++;
      if (init_done_o !== 1'b0) begin
         n_errors++;
         $display("FAIL fifo_fill: init_done=%b after 4 pushes, required 0", init_done_o);
      end
      send_req(1'b1, 8'h65, 1'b0, w);
      n_checks++;
      if (init_done_o !== 1'b1) begin
         n_errors++;
         $display("FAIL fifo_stall: init_done=%b when 5th accepted, required 1", init_done_o);
      end
      busy_len(k);
      n_checks++;
      if (n_writes - n0 != 9 || exp_q.size() != 0) begin
         n_errors++;
         $display("FAIL fifo_drain: %0d writes %0d pending, required 9 0", n_writes - n0, exp_q.size());
      end
   endtask
`endif

   initial begin
      fork
         monitor();
      join_none
      test_reset();
      test_init();
      test_user_write();
      test_back_to_back();
      test_exec_delays();
      test_reset_mid_pulse();
`ifdef LCD_CTRL_FIFO_EN
      test_fifo();
`endif
      n_checks++;
      if (rw_bad || exp_q.size() != 0) begin
         n_errors++;
         $display("FAIL final: rw_seen_high=%0d pending=%0d, required 0 0", rw_bad, exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
